arb_client: RTL and testbench

Requester-side agent for the four-way request/grant arbiter: the logic that sits at one `req_n`/`gnt_n` pair and drives it. It accepts burst jobs from local logic over a valid/ready handshake, then raises `req` and counts granted cycles (beats) until the job completes. It then drops `req` and holds it low for a minimum gap so the arbiter can return to idle. A wait timeout aborts jobs that are never granted.

---
 rtl/arb_client_pkg.sv | 23 ++
 rtl/arb_client_cnt.sv | 42 ++++
 rtl/arb_client.sv | 178 +++++++++++++++++
 tb/tb_arb_client.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_client_pkg.sv
// Shared definitions for the arbiter requester agent: state encoding,
// default parameter values and a width helper for the wait/gap timer.
package arb_client_pkg;

  localparam int DEF_LEN_W   = 4;
  localparam int DEF_GAP     = 2;
  localparam int DEF_TIMEOUT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_XFER = 2'b10,
    ST_GAP  = 2'b11
  } state_e;

  // The wait/gap timer must hold the larger of the two limits without wrapping.
  function automatic int timer_width(input int timeout, input int gap);
    int top;
    top = (timeout > gap) ? timeout : gap;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/arb_client_cnt.sv
// Loadable up/down counter with a terminal-count flag. It saturates at
// both ends so a stray enable can never make it wrap around.
module arb_client_cnt #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         count_up,
  input  logic         count_down,
  input  logic [W-1:0] tc_value,
  output logic         at_tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority over counting; each direction stops at its limit.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_up && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end else if (count_down && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register, cleared by the synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_tc = (count_q == tc_value);

endmodule

// File: rtl/arb_client.sv
// Requester-side agent for one req/gnt pair of the four-way arbiter.
// Accepts burst jobs, requests the bus, counts granted beats, enforces a
// minimum low gap on req afterwards and aborts jobs that are never granted.
module arb_client
  import arb_client_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat,
  output logic             done,
  output logic             timeout
);

  localparam int TMR_W = timer_width(TIMEOUT, GAP);

  // Timer compare points: the wait phase counts up from zero and expires on
  // its TIMEOUT-th ungranted cycle; the gap phase counts down from GAP and
  // leaves on the cycle where one remains.
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] BEAT_LAST = LEN_W'(1);

  state_e state_q;
  state_e state_d;

  logic req_q;
  logic req_d;
  logic done_q;
  logic done_d;
  logic timeout_q;
  logic timeout_d;

  logic job_nonzero;
  logic accept;
  logic last_beat;
  logic wait_expire;
  logic enter_gap;

  logic beat_at_last;
  logic tmr_at_tc;
  logic tmr_load;
  logic [TMR_W-1:0] tmr_load_value;
  logic tmr_up;
  logic tmr_down;
  logic [TMR_W-1:0] tmr_tc_value;

  assign job_nonzero  = (job_len != '0);
  assign tmr_tc_value = (state_q == ST_GAP) ? GAP_LAST : WAIT_LAST;

  // Beat counter: loaded with the job length, decremented on every beat.
  arb_client_cnt #(
    .W(LEN_W)
  ) u_beat_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (accept && job_nonzero),
    .load_value (job_len),
    .count_up   (1'b0),
    .count_down (beat),
    .tc_value   (BEAT_LAST),
    .at_tc      (beat_at_last)
  );

  // Shared timer: counts ungranted cycles in REQ, then the length of GAP.
  arb_client_cnt #(
    .W(TMR_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .count_up   (tmr_up),
    .count_down (tmr_down),
    .tc_value   (tmr_tc_value),
    .at_tc      (tmr_at_tc)
  );

  // State register; a reset drops any job in flight without reporting it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in REQ a grant beats a simultaneous timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (job_valid && job_nonzero) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          state_d = beat_at_last ? ST_GAP : ST_XFER;
        end else if (tmr_at_tc) begin
          state_d = ST_GAP;
        end
      end
      ST_XFER: begin
        if (gnt && beat_at_last) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_at_tc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: combinational handshake/beat plus next values of the
  // registered req, done and timeout outputs.
  always_comb begin
    job_ready   = (state_q == ST_IDLE);
    beat        = gnt && ((state_q == ST_REQ) || (state_q == ST_XFER));
    accept      = job_valid && job_ready;
    last_beat   = beat && beat_at_last;
    wait_expire = (state_q == ST_REQ) && !gnt && tmr_at_tc;
    req_d       = (state_d == ST_REQ) || (state_d == ST_XFER);
    done_d      = (accept && !job_nonzero) || last_beat;
    timeout_d   = wait_expire;
  end

  assign enter_gap = last_beat || wait_expire;

  // Timer control: clear on acceptance, preload GAP when the job ends,
  // count ungranted REQ cycles up and GAP cycles down.
  always_comb begin
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    tmr_up         = 1'b0;
    tmr_down       = 1'b0;
    if (accept && job_nonzero) begin
      tmr_load = 1'b1;
    end else if (enter_gap) begin
      tmr_load       = 1'b1;
      tmr_load_value = GAP_LOAD;
    end else if ((state_q == ST_REQ) && !gnt) begin
      tmr_up = 1'b1;
    end else if (state_q == ST_GAP) begin
      tmr_down = 1'b1;
    end
  end

  // Registered outputs so req, done and timeout are glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign req     = req_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb_client.sv
// Self-checking bench for arb_client: directed per-cycle stimulus tables,
// a job-level expectation model and literal pins on captured outputs.
module tb_arb_client;

  localparam int LEN_W   = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 8;
  localparam int MAXC    = 24;

  logic             clock;
  logic             reset;
  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             req;
  logic             gnt;
  logic             beat;
  logic             done;
  logic             timeout;

  arb_client #(
    .LEN_W  (LEN_W),
    .GAP    (GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .job_valid (job_valid),
    .job_len   (job_len),
    .job_ready (job_ready),
    .req       (req),
    .gnt       (gnt),
    .beat      (beat),
    .done      (done),
    .timeout   (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_checks = 0;
  int    n_errors = 0;
  bit    chk_on   = 1'b0;
  int    cur_cyc  = 0;
  string cur_name = "none";

  logic             st_valid [MAXC];
  logic [LEN_W-1:0] st_len   [MAXC];
  logic             st_gnt   [MAXC];
  logic             st_rst   [MAXC];

  logic exp_req [MAXC];
  logic exp_beat[MAXC];
  logic exp_done[MAXC];
  logic exp_to  [MAXC];
  logic exp_rdy [MAXC];

  logic cap_req [MAXC];
  logic cap_beat[MAXC];
  logic cap_done[MAXC];
  logic cap_to  [MAXC];
  logic cap_rdy [MAXC];

  // Single comparison point; every failure prints one FAIL line.
  task automatic checkOutput(input string what, input int cyc, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s %s cycle %0d: got %b expected %b", cur_name, what, cyc, act, exp);
    end
  endtask

  // Clear the stimulus table and poison the capture buffers.
  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_valid[i] = 1'b0;
      st_len[i]   = '0;
      st_gnt[i]   = 1'b0;
      st_rst[i]   = 1'b0;
      cap_req[i]  = 1'bx;
      cap_beat[i] = 1'bx;
      cap_done[i] = 1'bx;
      cap_to[i]   = 1'bx;
      cap_rdy[i]  = 1'bx;
    end
  endtask

  // Job-level model: walk each accepted job through its granted cycles,
  // then mark the completion pulse and the enforced gap.
  task automatic build_model(input int n);
    int c;
    int k;
    int len;
    int got;
    int waited;
    bit aborted;
    bit killed;
    for (int i = 0; i < MAXC; i++) begin
      exp_req[i]  = 1'b0;
      exp_beat[i] = 1'b0;
      exp_done[i] = 1'b0;
      exp_to[i]   = 1'b0;
      exp_rdy[i]  = 1'b1;
    end
    c = 0;
    while (c < n) begin
      if (st_valid[c] && !st_rst[c]) begin
        len = int'(st_len[c]);
        if (len == 0) begin
          if (c + 1 < n) exp_done[c + 1] = 1'b1;
          c++;
        end else begin
          k = c + 1;
          got = 0;
          waited = 0;
          aborted = 1'b0;
          killed = 1'b0;
          while (k < n) begin
            exp_rdy[k] = 1'b0;
            exp_req[k] = 1'b1;
            if (st_gnt[k]) begin
              exp_beat[k] = 1'b1;
              got++;
            end else if (got == 0) begin
              waited++;
              if (waited == TIMEOUT) aborted = 1'b1;
            end
            if (st_rst[k]) begin
              killed = 1'b1;
              break;
            end
            if (got == len || aborted) break;
            k++;
          end
          if (killed) begin
            c = k + 1;
          end else begin
            if (k + 1 < n) begin
              if (aborted) exp_to[k + 1] = 1'b1;
              else         exp_done[k + 1] = 1'b1;
            end
            for (int g = 1; g <= GAP; g++) begin
              if (k + g < n) exp_rdy[k + g] = 1'b0;
            end
            c = k + GAP + 1;
          end
        end
      end else begin
        c++;
      end
    end
  endtask

  // Compare process: checks every output against the model each cycle.
  always @(negedge clock) begin
    if (chk_on) begin
      cap_req[cur_cyc]  <= req;
      cap_beat[cur_cyc] <= beat;
      cap_done[cur_cyc] <= done;
      cap_to[cur_cyc]   <= timeout;
      cap_rdy[cur_cyc]  <= job_ready;
      checkOutput("req",       cur_cyc, req,       exp_req[cur_cyc]);
      checkOutput("beat",      cur_cyc, beat,      exp_beat[cur_cyc]);
      checkOutput("done",      cur_cyc, done,      exp_done[cur_cyc]);
      checkOutput("timeout",   cur_cyc, timeout,   exp_to[cur_cyc]);
      checkOutput("job_ready", cur_cyc, job_ready, exp_rdy[cur_cyc]);
    end
  end

  // Two reset cycles, outputs checked while reset is still held.
  task automatic do_reset();
    reset     = 1'b1;
    job_valid = 1'b0;
    job_len   = '0;
    gnt       = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("reset req",     0, req,     1'b0);
    checkOutput("reset done",    0, done,    1'b0);
    checkOutput("reset timeout", 0, timeout, 1'b0);
    checkOutput("reset beat",    0, beat,    1'b0);
    reset = 1'b0;
  endtask

  // Drive the stimulus table one cycle at a time, starting right after reset.
  task automatic applyStimulus(input string name, input int n);
    cur_name = name;
    build_model(n);
    for (int c = 0; c < n; c++) begin
      cur_cyc   = c;
      reset     = st_rst[c];
      job_valid = st_valid[c];
      job_len   = st_len[c];
      gnt       = st_gnt[c];
      chk_on    = 1'b1;
      @(posedge clock); #1;
    end
    chk_on    = 1'b0;
    reset     = 1'b0;
    job_valid = 1'b0;
    job_len   = '0;
    gnt       = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    job_valid = 1'b0;
    job_len   = '0;
    gnt       = 1'b0;

    $display("[TB] starting arb_client bench");

    do_reset();
    clear_stim();
    st_valid[0] = 1'b1;
    st_len[0]   = 4'd3;
    for (int c = 2; c <= 6; c++) st_gnt[c] = 1'b1;
    applyStimulus("normal", 10);
    checkOutput("pin req",   1, cap_req[1],  1'b1);
    checkOutput("pin req",   4, cap_req[4],  1'b1);
    checkOutput("pin req",   5, cap_req[5],  1'b0);
    checkOutput("pin beat",  2, cap_beat[2], 1'b1);
    checkOutput("pin beat",  4, cap_beat[4], 1'b1);
    checkOutput("pin beat",  5, cap_beat[5], 1'b0);
    checkOutput("pin done",  5, cap_done[5], 1'b1);
    checkOutput("pin done",  6, cap_done[6], 1'b0);
    checkOutput("pin ready", 6, cap_rdy[6],  1'b0);
    checkOutput("pin ready", 7, cap_rdy[7],  1'b1);

    do_reset();
    clear_stim();
    st_valid[0] = 1'b1;
    st_len[0]   = 4'd2;
    applyStimulus("timeout", 13);
    checkOutput("pin req",     8,  cap_req[8],  1'b1);
    checkOutput("pin req",     9,  cap_req[9],  1'b0);
    checkOutput("pin timeout", 9,  cap_to[9],   1'b1);
    checkOutput("pin done",    9,  cap_done[9], 1'b0);
    checkOutput("pin ready",   10, cap_rdy[10], 1'b0);
    checkOutput("pin ready",   11, cap_rdy[11], 1'b1);

    do_reset();
    clear_stim();
    st_valid[0] = 1'b1;
    st_len[0]   = 4'd4;
    st_gnt[2] = 1'b1; st_gnt[3] = 1'b1; st_gnt[7] = 1'b1; st_gnt[8] = 1'b1;
    applyStimulus("preempt", 13);
    checkOutput("pin beat",    4, cap_beat[4], 1'b0);
    checkOutput("pin req",     5, cap_req[5],  1'b1);
    checkOutput("pin beat",    8, cap_beat[8], 1'b1);
    checkOutput("pin done",    9, cap_done[9], 1'b1);
    checkOutput("pin timeout", 9, cap_to[9],   1'b0);

    do_reset();
    clear_stim();
    st_valid[0] = 1'b1;
    st_len[0]   = 4'd0;
    applyStimulus("zero_len", 4);
    checkOutput("pin done",  1, cap_done[1], 1'b1);
    checkOutput("pin req",   1, cap_req[1],  1'b0);
    checkOutput("pin ready", 1, cap_rdy[1],  1'b1);
    checkOutput("pin done",  2, cap_done[2], 1'b0);

    do_reset();
    clear_stim();
    st_valid[0] = 1'b1;
    st_len[0]   = 4'd1;
    st_gnt[8]   = 1'b1;
    applyStimulus("race", 13);
    checkOutput("pin beat",    8, cap_beat[8], 1'b1);
    checkOutput("pin timeout", 9, cap_to[9],   1'b0);
    checkOutput("pin done",    9, cap_done[9], 1'b1);

    do_reset();
    clear_stim();
    st_valid[0] = 1'b1;
    st_len[0]   = 4'd5;
    st_gnt[2]   = 1'b1;
    st_rst[3]   = 1'b1;
    st_valid[4] = 1'b1;
    st_len[4]   = 4'd1;
    st_gnt[6]   = 1'b1;
    applyStimulus("mid_reset", 10);
    checkOutput("pin req",   4, cap_req[4],  1'b0);
    checkOutput("pin ready", 4, cap_rdy[4],  1'b1);
    checkOutput("pin done",  4, cap_done[4], 1'b0);
    checkOutput("pin req",   5, cap_req[5],  1'b1);
    checkOutput("pin done",  7, cap_done[7], 1'b1);
    checkOutput("pin ready", 9, cap_rdy[9],  1'b1);

    do_reset();
    clear_stim();
    for (int c = 0; c < 12; c++) begin
      st_valid[c] = 1'b1;
      st_len[c]   = 4'd1;
      st_gnt[c]   = 1'b1;
    end
    applyStimulus("back_to_back", 12);
    checkOutput("pin beat",  0, cap_beat[0], 1'b0);
    checkOutput("pin req",   1, cap_req[1],  1'b1);
    checkOutput("pin beat",  2, cap_beat[2], 1'b0);
    checkOutput("pin req",   3, cap_req[3],  1'b0);
    checkOutput("pin ready", 4, cap_rdy[4],  1'b1);
    checkOutput("pin req",   5, cap_req[5],  1'b1);
    checkOutput("pin done",  6, cap_done[6], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
